// File: rtl/revcomp_stream.sv
// revcomp_stream: store-and-forward reverse-complement engine for packed DNA words.
// Words are buffered until in_last (or DEPTH words), then replayed through a
// registered output stage with optional word-order and base-order reversal and
// per-base complement, under valid/ready backpressure.
module revcomp_stream #(
   parameter int N     = 4,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*N-1:0]   in_word,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   out_word,
   output logic             out_last,
   output logic             overflow
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH);

   localparam logic S_LOAD  = 1'b0;
   localparam logic S_DRAIN = 1'b1;

   logic             state;
   logic [CW-1:0]    count;
   logic [CW-1:0]    rd_ptr;
   logic [1:0]       mode_q;
   logic [2*N-1:0]   mem [DEPTH];

   logic             accept;
   logic             more;
   logic [CW-1:0]    rd_idx;
   logic [2*N-1:0]   rd_word;

   // mode bit 1 reverses base order, bit 0 complements each base (flip bit 0)
   function automatic logic [2*N-1:0] xform(input logic [2*N-1:0] w, input logic [1:0] m);
      logic [1:0]     b;
      logic [2*N-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < N; i++) begin
         b = m[1] ? w[2*(N-1-i) +: 2] : w[2*i +: 2];
         r[2*i +: 2] = {b[1], b[0] ^ m[0]};
      end
      return r;
   endfunction

   assign in_ready = (state == S_LOAD);
   assign accept   = in_valid & in_ready;
   assign more     = (rd_ptr < count);
   // reversing modes walk the buffer from the newest entry back to entry 0
   assign rd_idx   = mode_q[1] ? (count - 1'b1 - rd_ptr) : rd_ptr;
   assign rd_word  = mem[rd_idx[IW-1:0]];

   // buffer write port: one entry per accepted input word
   always_ff @(posedge clk) begin
      if (accept)
         mem[count[IW-1:0]] <= in_word;
   end

   // control FSM, output register and overflow pulse
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_LOAD;
         count     <= '0;
         rd_ptr    <= '0;
         mode_q    <= '0;
         out_valid <= 1'b0;
         out_word  <= '0;
         out_last  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         overflow <= 1'b0;
         case (state)
            S_LOAD: begin
               if (accept) begin
                  count <= count + 1'b1;
                  if (count == '0)
                     mode_q <= mode;
                  if (in_last || count == CW'(DEPTH - 1)) begin
                     state    <= S_DRAIN;
                     rd_ptr   <= '0;
                     overflow <= ~in_last;
                  end
               end
            end
            S_DRAIN: begin
               // output register refills when empty or when its word is taken
               if (!out_valid || out_ready) begin
                  if (out_valid && out_last) begin
                     state     <= S_LOAD;
                     count     <= '0;
                     rd_ptr    <= '0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                  end else if (more) begin
                     out_word  <= xform(rd_word, mode_q);
                     out_valid <= 1'b1;
                     out_last  <= (rd_ptr + 1'b1 == count);
                     rd_ptr    <= rd_ptr + 1'b1;
                  end
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_revcomp_stream.sv
// tb_revcomp_stream: directed self-checking bench for revcomp_stream (N=4, DEPTH=4).
module tb_revcomp_stream;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_word;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_word;
   logic       out_last;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   revcomp_stream #(.N(4), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_word   (in_word),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .out_last  (out_last),
      .overflow  (overflow)
   );

   // free-running clock, 10 time-unit period
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present one word and hold it until the handshake edge has passed
   task automatic send_word(input logic [7:0] w, input logic l, input logic [1:0] m, input string tag);
      int t;
      in_valid = 1'b1;
      in_word  = w;
      in_last  = l;
      mode     = m;
      t = 0;
      while (!in_ready && t < 40) begin
         tick();
         t++;
      end
      check({tag, "_in_ready"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // wait for a valid output word, compare it, and let it be taken on the next edge
   task automatic recv(input logic [7:0] w, input logic l, input string tag);
      int t;
      t = 0;
      while (!out_valid && t < 20) begin
         tick();
         t++;
      end
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_word"}, out_word, w);
      check({tag, "_last"}, out_last, l);
      tick();
   endtask

   initial begin
      rst = 1'b0; mode = 2'b00; in_valid = 1'b0; in_word = '0; in_last = 1'b0; out_ready = 1'b1;
      tick();
      tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_word", out_word, 0);
      check("rst_out_last", out_last, 0);
      check("rst_overflow", overflow, 0);
      rst = 1'b1;
      tick();

      // 1: reverse-complement of two words, with latency check
      send_word(8'h1B, 1'b0, 2'b11, "t1_w0");
      send_word(8'h00, 1'b1, 2'b11, "t1_w1");
      check("t1_lat_valid0", out_valid, 0);
      check("t1_lat_in_ready0", in_ready, 0);
      tick();
      check("t1_lat_valid1", out_valid, 1);
      recv(8'h55, 1'b0, "t1_o0");
      recv(8'hB1, 1'b1, "t1_o1");
      check("t1_bubble_in_ready", in_ready, 1);

      // 2: single-word sequences, complement and reverse
      send_word(8'h1B, 1'b1, 2'b01, "t2a_w");
      recv(8'h4E, 1'b1, "t2a_o");
      send_word(8'h1B, 1'b1, 2'b10, "t2b_w");
      recv(8'hE4, 1'b1, "t2b_o");

      // 3: overflow truncation at DEPTH, fifth word held off until next sequence
      send_word(8'h01, 1'b0, 2'b00, "t3_w1");
      send_word(8'h02, 1'b0, 2'b00, "t3_w2");
      send_word(8'h03, 1'b0, 2'b00, "t3_w3");
      send_word(8'h04, 1'b0, 2'b00, "t3_w4");
      check("t3_overflow_pulse", overflow, 1);
      in_valid = 1'b1; in_word = 8'h05; in_last = 1'b1;
      tick();
      check("t3_overflow_clear", overflow, 0);
      recv(8'h01, 1'b0, "t3_o1");
      recv(8'h02, 1'b0, "t3_o2");
      check("t3_overflow_quiet", overflow, 0);
      recv(8'h03, 1'b0, "t3_o3");
      recv(8'h04, 1'b1, "t3_o4");
      send_word(8'h05, 1'b1, 2'b00, "t3_w5");
      recv(8'h05, 1'b1, "t3_o5");

      // 4: backpressure mid-drain
      send_word(8'h1B, 1'b0, 2'b11, "t4_w0");
      send_word(8'hE4, 1'b0, 2'b11, "t4_w1");
      send_word(8'h0F, 1'b1, 2'b11, "t4_w2");
      recv(8'hA5, 1'b0, "t4_o0");
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t4_stall_valid", out_valid, 1);
         check("t4_stall_word", out_word, 8'h4E);
         check("t4_stall_last", out_last, 0);
         check("t4_stall_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      recv(8'h4E, 1'b0, "t4_o1");
      check("t4_in_ready_drain", in_ready, 0);
      recv(8'hB1, 1'b1, "t4_o2");

      // 5: reset mid-load discards the partial sequence
      send_word(8'h11, 1'b0, 2'b11, "t5_w0");
      send_word(8'h22, 1'b0, 2'b11, "t5_w1");
      rst = 1'b0;
      tick();
      check("t5_rst_out_valid", out_valid, 0);
      check("t5_rst_in_ready", in_ready, 1);
      check("t5_rst_out_last", out_last, 0);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t5_no_output", out_valid, 0);
      end
      send_word(8'hFF, 1'b1, 2'b11, "t5_w2");
      recv(8'hAA, 1'b1, "t5_o");

      // 6: mode toggles during load; first-word mode (complement) must stick
      send_word(8'h1B, 1'b0, 2'b01, "t6_w0");
      mode = 2'b11;
      tick();
      send_word(8'hE4, 1'b0, 2'b10, "t6_w1");
      send_word(8'h00, 1'b1, 2'b11, "t6_w2");
      mode = 2'b00;
      recv(8'h4E, 1'b0, "t6_o0");
      mode = 2'b10;
      recv(8'hB1, 1'b0, "t6_o1");
      recv(8'h55, 1'b1, "t6_o2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
